// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Covers FSM states, opcode/funct values and datapath select codes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXE,
    S_R_WB,
    S_I_EXE,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR
  } state_e;

  typedef enum logic [2:0] {
    AOP_NONE,
    AOP_ADD,
    AOP_SUB,
    AOP_SLT,
    AOP_FUNCT
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  function automatic logic is_r_alu(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// Maps the controller's ALU operation class and funct to alu_ctrl.
// Narrow 3-bit codes are zero-extended to ALU_CTRL_W.
module mips_mc_alu_decoder
  import mips_mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  alu_op_e               op_i,
  input  logic [5:0]            funct_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

  logic [2:0] code;

  always_comb begin
    code = 3'b000;
    unique case (op_i)
      AOP_ADD: code = ALU_ADD;
      AOP_SUB: code = ALU_SUB;
      AOP_SLT: code = ALU_SLT;
      AOP_FUNCT: begin
        unique case (funct_i)
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: code = ALU_ADD;
        endcase
      end
      default: code = 3'b000;
    endcase
  end

  assign alu_ctrl_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with memory wait states and watchdog.
// Define MIPS_MC_BNE_EN to decode bne onto the BRANCH state.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int MAX_WAIT   = 0,
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [5:0]            opcode_i,
  input  logic [5:0]            funct_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output logic                  pc_en_o,
  output logic [1:0]            pc_src_o,
  output logic                  i_or_d_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  ir_write_o,
  output logic [1:0]            reg_dst_o,
  output logic [1:0]            mem_to_reg_o,
  output logic                  reg_write_o,
  output logic                  alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  illegal_o,
  output logic                  mem_timeout_o
);

  localparam bit WD_EN = (MAX_WAIT > 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'(WD_EN ? MAX_WAIT - 1 : 0);

  state_e                state_q, state_d, st;
  state_e                dec_nxt;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  rdy, mem_st, tmo;
  logic                  dec_ill, bne_q;
  alu_op_e               alu_op;

  // Reset masks the live state so a dropped access looks like FETCH.
  assign st     = rst_i ? S_FETCH : state_q;
  assign rdy    = mem_ready_i & ~rst_i;
  assign mem_st = st inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign tmo    = WD_EN & mem_st & ~rdy & ~rst_i
                & (wait_q == WAIT_LAST);
  assign wait_d = (mem_st & ~rdy & ~tmo) ? wait_q + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef MIPS_MC_BNE_EN
  logic bne_d, dec_bne;

  assign bne_d = (state_q == S_DECODE) ? dec_bne : bne_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) bne_q <= 1'b0;
    else       bne_q <= bne_d;
  end
`else
  assign bne_q = 1'b0;
`endif

  always_comb begin
    dec_nxt = S_FETCH;
    dec_ill = 1'b1;
`ifdef MIPS_MC_BNE_EN
    dec_bne = 1'b0;
`endif
    unique case (1'b1)
      opcode_i == OP_RTYPE && funct_i == FN_JR: begin
        dec_nxt = S_JR;
        dec_ill = 1'b0;
      end
      opcode_i == OP_RTYPE && is_r_alu(funct_i): begin
        dec_nxt = S_R_EXE;
        dec_ill = 1'b0;
      end
      opcode_i == OP_LW || opcode_i == OP_SW: begin
        dec_nxt = S_MEM_ADR;
        dec_ill = 1'b0;
      end
      opcode_i == OP_ADDI || opcode_i == OP_SLTI: begin
        dec_nxt = S_I_EXE;
        dec_ill = 1'b0;
      end
      opcode_i == OP_BEQ: begin
        dec_nxt = S_BRANCH;
        dec_ill = 1'b0;
      end
`ifdef MIPS_MC_BNE_EN
      opcode_i == OP_BNE: begin
        dec_nxt = S_BRANCH;
        dec_ill = 1'b0;
        dec_bne = 1'b1;
      end
`endif
      opcode_i == OP_J: begin
        dec_nxt = S_JUMP;
        dec_ill = 1'b0;
      end
      opcode_i == OP_JAL: begin
        dec_nxt = S_JAL;
        dec_ill = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = dec_nxt;
      S_MEM_ADR: state_d = (opcode_i == OP_LW) ? S_MEM_RD
                                               : S_MEM_WR;
      S_MEM_RD: begin
        if (rdy)      state_d = S_MEM_WB;
        else if (tmo) state_d = S_FETCH;
      end
      S_MEM_WR: begin
        if (rdy || tmo) state_d = S_FETCH;
      end
      S_R_EXE:   state_d = S_R_WB;
      S_I_EXE:   state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_en_o       = 1'b0;
    pc_src_o      = PC_ALU;
    i_or_d_o      = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_dst_o     = RD_RT;
    mem_to_reg_o  = M2R_ALU;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRCB_B;
    alu_op        = AOP_NONE;
    illegal_o     = 1'b0;
    mem_timeout_o = 1'b0;
    unique case (st)
      S_FETCH: begin
        mem_read_o    = 1'b1;
        alu_src_b_o   = SRCB_FOUR;
        alu_op        = AOP_ADD;
        ir_write_o    = rdy;
        pc_en_o       = rdy;
        mem_timeout_o = tmo;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        alu_op      = AOP_ADD;
        illegal_o   = dec_ill;
      end
      S_MEM_ADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op      = AOP_ADD;
      end
      S_MEM_RD: begin
        mem_read_o    = 1'b1;
        i_or_d_o      = 1'b1;
        mem_timeout_o = tmo;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
      end
      S_MEM_WR: begin
        mem_write_o   = 1'b1;
        i_or_d_o      = 1'b1;
        mem_timeout_o = tmo;
      end
      S_R_EXE: begin
        alu_src_a_o = 1'b1;
        alu_op      = AOP_FUNCT;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = RD_RD;
      end
      S_I_EXE: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op      = (opcode_i == OP_SLTI) ? AOP_SLT : AOP_ADD;
      end
      S_I_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op      = AOP_SUB;
        pc_src_o    = PC_ALUOUT;
        pc_en_o     = zero_i ^ bne_q;
      end
      S_JUMP: begin
        pc_src_o = PC_JUMP;
        pc_en_o  = 1'b1;
      end
      S_JAL: begin
        pc_src_o     = PC_JUMP;
        pc_en_o      = 1'b1;
        reg_write_o  = 1'b1;
        reg_dst_o    = RD_R31;
        mem_to_reg_o = M2R_PC;
      end
      S_JR: begin
        pc_src_o = PC_RS;
        pc_en_o  = 1'b1;
      end
      default: ;
    endcase
  end

  mips_mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .op_i       (alu_op),
    .funct_i    (funct_i),
    .alu_ctrl_o (alu_ctrl_o)
  );

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Parametrised multicycle control unit, the successor to the single-cycle controller. It sequences each instruction through an FSM over a shared datapath and a unified instruction/data memory. Memory accesses use a ready handshake with wait states and an optional watchdog. The unit sits beside the multicycle datapath in the core top, driving register enables and mux selects from the IR opcode/funct and the ALU zero flag.

Parameters:
ALU_CTRL_W, 3, width of alu_ctrl (codes: 010 add, 110 sub, 000 and, 001 or, 111 slt; zero-extended if wider).
MAX_WAIT, 0, memory watchdog limit in cycles; 0 disables the watchdog.
WAIT_CNT_W, 8, width of the wait counter; MAX_WAIT must be < 2^WAIT_CNT_W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current read/write this cycle
pc_en  output  1  PC register write enable
pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
i_or_d  output  1  memory address select: 0 PC, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
reg_dst  output  2  00 rt, 01 rd, 10 r31
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
reg_write  output  1  register file write
alu_src_a  output  1  0 PC, 1 A
alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_ctrl  output  ALU_CTRL_W  ALU operation
illegal  output  1  one-cycle pulse on an unsupported opcode/funct
mem_timeout  output  1  one-cycle pulse on a watchdog expiry

Behaviour:
- Reset: state=FETCH, wait counter=0. All outputs except those asserted in FETCH are 0. Reset wins over every other event, including mid-access; any pending memory request is dropped.
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, I_EXE, I_WB, BRANCH, JUMP, JAL, JR.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add. Holds while mem_ready=0. When mem_ready=1: ir_write=1, pc_en=1, pc_src=00, next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (precomputes the branch target). Next state by opcode:
  - 000000 with funct 001000 → JR; other legal funct → R_EXE.
  - 100011 / 101011 → MEM_ADR.
  - 001000 (addi) / 001010 (slti) → I_EXE.
  - 000100 → BRANCH; 000010 → JUMP; 000011 → JAL.
  - Anything else: illegal=1, next state FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=10, add. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- R_EXE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Other funct is caught in DECODE as illegal.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
- I_EXE: alu_src_a=1, alu_src_b=10, alu_ctrl add (addi) or slt (slti).
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero.
- JUMP: pc_src=10, pc_en=1.
- JAL: pc_src=10, pc_en=1, reg_write=1, reg_dst=10, mem_to_reg=10. The PC already holds PC+4 at this point.
- JR: pc_src=11, pc_en=1.
- All single-cycle states return to FETCH.
- Cycle counts at zero wait: lw 5, sw/R/I 4, beq/j/jal/jr 3. Each memory wait cycle adds 1.
- Wait counter:
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - Clears on mem_ready or on leaving those states.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT: mem_timeout=1 for one cycle, the counter clears, state goes to FETCH. ir_write, pc_en and reg_write all stay 0.
  - mem_ready=1 in the same cycle as expiry takes priority over the timeout.
- mem_read and mem_write are never both 1.

Optional Feature:
MIPS_MC_BNE_EN:
- Defined: opcode 000101 (bne) is decoded to the BRANCH state with an internal bne flag, so pc_en=~zero.
- Undefined: 000101 is illegal (pulse illegal, return to FETCH).

Decomposition:
- Package mips_mc_pkg holds:
  - state enum typedef;
  - opcode/funct localparams;
  - ALU code constants;
  - pc_src, reg_dst, mem_to_reg and alu_src_b select encodings.
- One sub-module, mips_mc_alu_decoder: combinational mapping of state-class and funct to alu_ctrl.
- The FSM and wait counter stay in the top block.

Test Plan:
- lw with mem_ready tied high → 5 cycles; MEM_WB asserts reg_write=1, mem_to_reg=01, reg_dst=00; exactly one ir_write pulse.
- sw with mem_ready low for 3 cycles in MEM_WR → mem_write held 4 cycles, then FETCH; reg_write never 1.
- beq with zero=1 → pc_en=1, pc_src=01 in BRANCH. beq with zero=0 → pc_en=0 in BRANCH.
- jal → one cycle with pc_en=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. jr (funct 001000) → pc_src=11.
- MAX_WAIT=4 with mem_ready stuck low in FETCH → mem_timeout pulses on the 4th wait cycle, returns to FETCH, no ir_write. Opcode 111111 → illegal pulse in DECODE.
- rst asserted during MEM_RD wait → next cycle state=FETCH, mem_read=1, i_or_d=0, all other enables 0.
